processor_controller: RTL and testbench

- Control unit FSM for the 16-bit datapath.
- Owns the program counter (PC) and instruction register (IR).
- Fetches instructions from instruction memory and decodes them.
- Sequences the register-file write/read ports, data-memory read/write, the writeback mux select and the ALU op select.
- It is the initiator of the register file write/read-address interface; the datapath consumes its outputs.

---
 rtl/processor_controller.sv | 132 +++++++++++++
 tb/tb_processor_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/processor_controller.sv
// Control-unit FSM for the 16-bit datapath: owns PC and IR, fetches, decodes and sequences
// register-file, data-memory and ALU controls. Optional single-step gate on FETCH: PROC_STEP_EN.
module processor_controller #(
  parameter int PC_WIDTH      = 7,
  parameter int D_ADDR_WIDTH  = 8,
  parameter int RF_ADDR_WIDTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
`ifdef PROC_STEP_EN
  input  logic                     Step,
`endif
  input  logic [15:0]              Instr_Data,
  output logic [PC_WIDTH-1:0]      PC_Addr,
  output logic [D_ADDR_WIDTH-1:0]  D_Addr,
  output logic                     D_Rd,
  output logic                     D_Wr,
  output logic                     RF_s,
  output logic                     RF_W_en,
  output logic [RF_ADDR_WIDTH-1:0] RF_W_addr,
  output logic [RF_ADDR_WIDTH-1:0] RF_Ra_addr,
  output logic [RF_ADDR_WIDTH-1:0] RF_Rb_addr,
  output logic [2:0]               ALU_s0,
  output logic [3:0]               State,
  output logic                     Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic                fetch_go;

`ifdef PROC_STEP_EN
  assign fetch_go = Step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && fetch_go) begin
        ir <= Instr_Data;
        pc <= pc + PC_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        // Opcodes 0110-1111 are unassigned and fall through to NOOP.
        unique case (ir[15:12])
          4'b0001: state_nxt = S_STORE;
          4'b0010: state_nxt = S_LOAD_A;
          4'b0011: state_nxt = S_ADD;
          4'b0100: state_nxt = S_SUB;
          4'b0101: state_nxt = S_HALT;
          default: state_nxt = S_NOOP;
        endcase
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    D_Addr     = '0;
    D_Rd       = 1'b0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = 3'd0;
    Halted     = 1'b0;
    unique case (state)
      S_LOAD_A: begin
        D_Addr = D_ADDR_WIDTH'(ir[11:4]);
        D_Rd   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr    = D_ADDR_WIDTH'(ir[11:4]);
        D_Rd      = 1'b1;
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_addr = RF_ADDR_WIDTH'(ir[3:0]);
      end
      S_STORE: begin
        D_Addr     = D_ADDR_WIDTH'(ir[7:0]);
        D_Wr       = 1'b1;
        RF_Ra_addr = RF_ADDR_WIDTH'(ir[11:8]);
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = RF_ADDR_WIDTH'(ir[11:8]);
        RF_Rb_addr = RF_ADDR_WIDTH'(ir[7:4]);
        RF_W_addr  = RF_ADDR_WIDTH'(ir[3:0]);
        RF_W_en    = 1'b1;
        ALU_s0     = (state == S_ADD) ? 3'd1 : 3'd2;
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign PC_Addr = pc;
  assign State   = state;

endmodule

// File: tb/tb_processor_controller.sv
// Scoreboard bench for processor_controller: stimulus queues expected per-cycle output
// vectors, a monitor pops and compares one per falling edge (or on an async sample event).
module tb_processor_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Instr_Data;
  logic [6:0]  PC_Addr;
  logic [7:0]  D_Addr;
  logic        D_Rd, D_Wr, RF_s, RF_W_en, Halted;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s0;
`ifdef PROC_STEP_EN
  logic        Step = 1'b1;
`endif

  logic [15:0] rom [128];
  assign Instr_Data = rom[PC_Addr];

  always #5 Clk = ~Clk;

  processor_controller #(.PC_WIDTH(7), .D_ADDR_WIDTH(8), .RF_ADDR_WIDTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
`ifdef PROC_STEP_EN
    .Step(Step),
`endif
    .Instr_Data(Instr_Data), .PC_Addr(PC_Addr), .D_Addr(D_Addr), .D_Rd(D_Rd), .D_Wr(D_Wr),
    .RF_s(RF_s), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .State(State), .Halted(Halted)
  );

  localparam logic [3:0] ST_INIT = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_NOOP = 4'd3,
                         ST_LOAD_A = 4'd4, ST_LOAD_B = 4'd5, ST_STORE = 4'd6, ST_ADD = 4'd7,
                         ST_SUB = 4'd8, ST_HALT = 4'd9;

  typedef struct {
    string       tag;
    logic [38:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  event sample_ev;

  // {State, PC, D_Addr, D_Rd, D_Wr, RF_s, RF_W_en, W_addr, Ra, Rb, ALU_s0, Halted}
  function automatic logic [38:0] mk(input logic [3:0] st, input logic [6:0] pc,
                                     input logic [7:0] da, input logic rd, input logic wr,
                                     input logic s, input logic we, input logic [3:0] wa,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [2:0] alu, input logic h);
    return {st, pc, da, rd, wr, s, we, wa, ra, rb, alu, h};
  endfunction

  task automatic push(input string tag, input logic [38:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic p_simple(input string tag, input logic [3:0] st, input logic [6:0] pc);
    push(tag, mk(st, pc, 8'h00, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 0));
  endtask

  initial begin
    exp_t        e;
    logic [38:0] act;
    forever begin
      @(negedge Clk or sample_ev);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {State, PC_Addr, D_Addr, D_Rd, D_Wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr,
               RF_Rb_addr, ALU_s0, Halted};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h (state %0d vs %0d) t=%0t",
                   e.tag, act, e.v, act[38:35], e.v[38:35], $time);
        end
      end
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_%s: pending=%0d required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start(input string tag);
    Reset = 1'b1;
    p_simple({tag, "_reset"}, ST_INIT, 7'd0);
    @(posedge Clk);
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic release_rst();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    // Reset-then-run and PC wrap with an all-NOOP program.
    start("wrap");
    release_rst();
    p_simple("wrap_init", ST_INIT, 7'd0);
    for (int k = 0; k < 130; k++) begin
      p_simple("wrap_fetch", ST_FETCH, 7'(k));
      p_simple("wrap_decode", ST_DECODE, 7'(k + 1));
      p_simple("wrap_noop", ST_NOOP, 7'(k + 1));
    end
    drain("wrap");

    // LOAD, ADD, SUB, STORE, HALT.
    start("prog");
    rom[0] = 16'h21B3; rom[1] = 16'h3125; rom[2] = 16'h4125; rom[3] = 16'h1A7F; rom[4] = 16'h5000;
    release_rst();
    p_simple("prog_init", ST_INIT, 7'd0);
    p_simple("prog_fetch0", ST_FETCH, 7'd0);
    p_simple("prog_decode0", ST_DECODE, 7'd1);
    push("load_a", mk(ST_LOAD_A, 7'd1, 8'h1B, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 0));
    push("load_b", mk(ST_LOAD_B, 7'd1, 8'h1B, 1, 0, 1, 1, 4'h3, 4'h0, 4'h0, 3'd0, 0));
    p_simple("prog_fetch1", ST_FETCH, 7'd1);
    p_simple("prog_decode1", ST_DECODE, 7'd2);
    push("add", mk(ST_ADD, 7'd2, 8'h00, 0, 0, 0, 1, 4'h5, 4'h1, 4'h2, 3'd1, 0));
    p_simple("prog_fetch2", ST_FETCH, 7'd2);
    p_simple("prog_decode2", ST_DECODE, 7'd3);
    push("sub", mk(ST_SUB, 7'd3, 8'h00, 0, 0, 0, 1, 4'h5, 4'h1, 4'h2, 3'd2, 0));
    p_simple("prog_fetch3", ST_FETCH, 7'd3);
    p_simple("prog_decode3", ST_DECODE, 7'd4);
    push("store", mk(ST_STORE, 7'd4, 8'h7F, 0, 1, 0, 0, 4'h0, 4'hA, 4'h0, 3'd0, 0));
    p_simple("prog_fetch4", ST_FETCH, 7'd4);
    p_simple("prog_decode4", ST_DECODE, 7'd5);
    for (int i = 0; i < 22; i++)
      push("prog_halt", mk(ST_HALT, 7'd5, 8'h00, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 1));
    drain("prog");

    // STORE at address 0 then HALT: PC parks at 2.
    start("sh");
    rom[0] = 16'h1A7F; rom[1] = 16'h5000;
    release_rst();
    p_simple("sh_init", ST_INIT, 7'd0);
    p_simple("sh_fetch0", ST_FETCH, 7'd0);
    p_simple("sh_decode0", ST_DECODE, 7'd1);
    push("sh_store", mk(ST_STORE, 7'd1, 8'h7F, 0, 1, 0, 0, 4'h0, 4'hA, 4'h0, 3'd0, 0));
    p_simple("sh_fetch1", ST_FETCH, 7'd1);
    p_simple("sh_decode1", ST_DECODE, 7'd2);
    for (int i = 0; i < 21; i++)
      push("sh_halt", mk(ST_HALT, 7'd2, 8'h00, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 1));
    drain("sh");

    // Illegal opcode, then asynchronous reset in the middle of LOAD_A.
    start("ill");
    rom[0] = 16'hF123; rom[1] = 16'h21B3;
    release_rst();
    p_simple("ill_init", ST_INIT, 7'd0);
    p_simple("ill_fetch0", ST_FETCH, 7'd0);
    p_simple("ill_decode0", ST_DECODE, 7'd1);
    p_simple("ill_noop", ST_NOOP, 7'd1);
    p_simple("ill_fetch1", ST_FETCH, 7'd1);
    p_simple("ill_decode1", ST_DECODE, 7'd2);
    push("ill_load_a", mk(ST_LOAD_A, 7'd2, 8'h1B, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 0));
    drain("ill");
    #1 Reset = 1'b1;
    #1 p_simple("async_reset", ST_INIT, 7'd0);
    ->sample_ev;
    #1;
    @(posedge Clk);
    #1 p_simple("reset_no_load_b", ST_INIT, 7'd0);
    drain("async");
    release_rst();
    p_simple("rerun_init", ST_INIT, 7'd0);
    p_simple("rerun_fetch0", ST_FETCH, 7'd0);
    p_simple("rerun_decode0", ST_DECODE, 7'd1);
    p_simple("rerun_noop", ST_NOOP, 7'd1);
    drain("rerun");

`ifdef PROC_STEP_EN
    // FETCH holds while Step is low.
    start("step");
    Step = 1'b0;
    release_rst();
    p_simple("step_init", ST_INIT, 7'd0);
    for (int i = 0; i < 6; i++) p_simple("step_hold", ST_FETCH, 7'd0);
    drain("step_hold");
    Step = 1'b1;
    p_simple("step_decode", ST_DECODE, 7'd1);
    p_simple("step_noop", ST_NOOP, 7'd1);
    drain("step_go");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t required=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
